dominant_controller: RTL

Control FSM that sequences the dominant-eigenvector power-iteration datapath. It issues single-cycle load/start strobes for load-vector, multiply, scale, diff and max-difference capture, and waits on the datapath done pulses. After each iteration it tests the captured max difference against a tolerance, then either repeats or terminates. It sits between the top-level start/status interface and the datapath, and is the command side of that datapath's strobe/done handshake.

---
 rtl/dominant_controller_if.sv | 32 +++
 rtl/dominant_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dominant_controller_if.sv
// +------------------------------------------------------------------------+
// | dominant_controller_if                                                 |
// | Command/response bundle between the power-iteration controller and    |
// | its datapath: single-cycle strobes out, done pulses and max diff back. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

interface dominant_controller_if;
  logic       load_v_old;
  logic       start_mult;
  logic       load_y;
  logic       start_scale;
  logic       start_diff;
  logic       load_max_d;
  logic       mul_done;
  logic       scale_done;
  logic       diff_done;
  logic [3:0] max_d_in;

  modport master (
    output load_v_old, start_mult, load_y, start_scale, start_diff, load_max_d,
    input  mul_done, scale_done, diff_done, max_d_in
  );

  modport slave (
    input  load_v_old, start_mult, load_y, start_scale, start_diff, load_max_d,
    output mul_done, scale_done, diff_done, max_d_in
  );
endinterface

`default_nettype wire

// File: rtl/dominant_controller.sv
// +------------------------------------------------------------------------+
// | dominant_controller                                                    |
// | Sequencing FSM for the dominant-eigenvector power iteration. Optional |
// | per-wait watchdog compiled in with DOMINANT_CTRL_WATCHDOG_EN.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module dominant_controller #(
  parameter int MAX_ITER    = 16,
  parameter int WDOG_CYCLES = 255
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   start,
  input  wire  [3:0]            tol,
  dominant_controller_if.master dp,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout,
  output logic [7:0]            iter_count
);

  localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOADV   = 4'd1,
    S_MULT    = 4'd2,
    S_MULT_W  = 4'd3,
    S_LOADY   = 4'd4,
    S_SCALE   = 4'd5,
    S_SCALE_W = 4'd6,
    S_DIFF    = 4'd7,
    S_DIFF_W  = 4'd8,
    S_LOADD   = 4'd9,
    S_CHECK   = 4'd10,
`ifdef DOMINANT_CTRL_WATCHDOG_EN
    S_FIN     = 4'd11,
    S_ERR     = 4'd12
`else
    S_FIN     = 4'd11
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tol_q, tol_d;
  logic [7:0] iter_q, iter_d;
  logic       conv_q, conv_d;
  logic       tmo_q, tmo_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load_v_old_q, load_v_old_d;
  logic       start_mult_q, start_mult_d;
  logic       load_y_q, load_y_d;
  logic       start_scale_q, start_scale_d;
  logic       start_diff_q, start_diff_d;
  logic       load_max_d_q, load_max_d_d;

`ifdef DOMINANT_CTRL_WATCHDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);
  logic [7:0] wdog_q, wdog_d;
  logic       wait_state;
  logic       wait_done;
`else
  // The watchdog limit only has meaning when the watchdog is compiled in.
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_wdog_cfg_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    tol_d   = tol_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADV;
          tol_d   = tol;
          iter_d  = 8'd0;
          conv_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_LOADV:   state_d = S_MULT;
      S_MULT:    state_d = S_MULT_W;
      S_MULT_W:  if (dp.mul_done)   state_d = S_LOADY;
      S_LOADY:   state_d = S_SCALE;
      S_SCALE:   state_d = S_SCALE_W;
      S_SCALE_W: if (dp.scale_done) state_d = S_DIFF;
      S_DIFF:    state_d = S_DIFF_W;
      S_DIFF_W:  if (dp.diff_done)  state_d = S_LOADD;
      S_LOADD:   state_d = S_CHECK;
      S_CHECK: begin
        iter_d = iter_q + 8'd1;
        if (dp.max_d_in <= tol_q) begin
          conv_d  = 1'b1;
          state_d = S_FIN;
        end else if (iter_q + 8'd1 == MAX_ITER_C) begin
          state_d = S_FIN;
        end else begin
          state_d = S_LOADV;
        end
      end
      S_FIN:     state_d = S_IDLE;
`ifdef DOMINANT_CTRL_WATCHDOG_EN
      S_ERR:     state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase

`ifdef DOMINANT_CTRL_WATCHDOG_EN
    wait_state = 1'b0;
    wait_done  = 1'b0;
    case (state_q)
      S_MULT_W:  begin wait_state = 1'b1; wait_done = dp.mul_done;   end
      S_SCALE_W: begin wait_state = 1'b1; wait_done = dp.scale_done; end
      S_DIFF_W:  begin wait_state = 1'b1; wait_done = dp.diff_done;  end
      default:   ;
    endcase
    if (wait_state && !wait_done && wdog_q == WDOG_LAST) begin
      state_d = S_ERR;
      tmo_d   = 1'b1;
      conv_d  = 1'b0;
    end
    // Counter restarts from zero on every entry into a wait state.
    wdog_d = (wait_state && state_d == state_q) ? wdog_q + 8'd1 : 8'd0;
`endif

    // Outputs are registered from the next state so they align with it.
    busy_d        = (state_d != S_IDLE);
`ifdef DOMINANT_CTRL_WATCHDOG_EN
    done_d        = (state_d == S_FIN) || (state_d == S_ERR);
`else
    done_d        = (state_d == S_FIN);
`endif
    load_v_old_d  = (state_d == S_LOADV);
    start_mult_d  = (state_d == S_MULT);
    load_y_d      = (state_d == S_LOADY);
    start_scale_d = (state_d == S_SCALE);
    start_diff_d  = (state_d == S_DIFF);
    load_max_d_d  = (state_d == S_LOADD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tol_q         <= 4'd0;
      iter_q        <= 8'd0;
      conv_q        <= 1'b0;
      tmo_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_v_old_q  <= 1'b0;
      start_mult_q  <= 1'b0;
      load_y_q      <= 1'b0;
      start_scale_q <= 1'b0;
      start_diff_q  <= 1'b0;
      load_max_d_q  <= 1'b0;
`ifdef DOMINANT_CTRL_WATCHDOG_EN
      wdog_q        <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      tol_q         <= tol_d;
      iter_q        <= iter_d;
      conv_q        <= conv_d;
      tmo_q         <= tmo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_v_old_q  <= load_v_old_d;
      start_mult_q  <= start_mult_d;
      load_y_q      <= load_y_d;
      start_scale_q <= start_scale_d;
      start_diff_q  <= start_diff_d;
      load_max_d_q  <= load_max_d_d;
`ifdef DOMINANT_CTRL_WATCHDOG_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign dp.load_v_old  = load_v_old_q;
  assign dp.start_mult  = start_mult_q;
  assign dp.load_y      = load_y_q;
  assign dp.start_scale = start_scale_q;
  assign dp.start_diff  = start_diff_q;
  assign dp.load_max_d  = load_max_d_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign timeout    = tmo_q;
  assign iter_count = iter_q;

endmodule

`default_nettype wire
